rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_pkg.sv | 5 +
 rtl/rr_grant_arbiter_decoder.sv | 11 +
 rtl/rr_grant_arbiter.sv | 64 ++++++
 tb/tb_rr_grant_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// rr_grant_arbiter_pkg: arbiter FSM states and hold-counter width.
package rr_grant_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam int HOLD_W = 8;
endpackage

// File: rtl/rr_grant_arbiter_decoder.sv
// rr_grant_arbiter_decoder: enabled binary-to-one-hot decoder.
module rr_grant_arbiter_decoder #(
  parameter int INPUT_SIZE = 3
) (
  input  logic                         enable_i,
  input  logic [INPUT_SIZE-1:0]        in_i,
  output logic [(2**INPUT_SIZE)-1:0]   out_o
);
  localparam int N = 2**INPUT_SIZE;
  assign out_o = enable_i ? N'(1) << in_i : '0;
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with bounded tenure (MAX_HOLD) and a
// one-cycle idle bubble between tenures.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int IDX_WIDTH = 3,
  parameter int MAX_HOLD  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**IDX_WIDTH)-1:0]   req,
  output logic [(2**IDX_WIDTH)-1:0]   gnt,
  output logic                        gnt_valid,
  output logic [IDX_WIDTH-1:0]        gnt_idx,
  output logic                        timeout
);
  localparam int N = 2**IDX_WIDTH;
  state_e               state_q;
  logic [IDX_WIDTH-1:0] owner_q, ptr_q, sel_off, sel_idx;
  logic [HOLD_W-1:0]    hold_q;
  logic                 timeout_q, busy, end_tenure;
  // Rotate by ptr and priority-encode: lowest offset from ptr wins.
  always_comb begin
    sel_off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[IDX_WIDTH'(i) + ptr_q]) sel_off = IDX_WIDTH'(i);
  end
  assign sel_idx    = ptr_q + sel_off;
  assign busy       = state_q == BUSY;
  assign end_tenure = !req[owner_q] || hold_q == HOLD_W'(MAX_HOLD);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      timeout_q <= 1'b0;
      if (|req) begin
        state_q <= BUSY;
        owner_q <= sel_idx;
        hold_q  <= HOLD_W'(1);
      end
    end else begin
      // A release wins over a coincident timeout.
      timeout_q <= end_tenure && req[owner_q];
      if (end_tenure) begin
        state_q <= IDLE;
        ptr_q   <= owner_q + 1'b1;
        hold_q  <= '0;
      end else begin
        hold_q  <= hold_q + 1'b1;
      end
    end
  rr_grant_arbiter_decoder #(.INPUT_SIZE(IDX_WIDTH)) u_dec (
    .enable_i (busy),
    .in_i     (owner_q),
    .out_o    (gnt)
  );
  assign gnt_valid = busy;
  assign gnt_idx   = busy ? owner_q : '0;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scoreboard bench plus random invariant/fairness run.
module tb_rr_grant_arbiter;
  localparam int N = 8;
  typedef struct packed {logic [7:0] g; logic v; logic [2:0] i; logic t;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;
  exp_t       q[$];
  int         total = 0;
  int         passed = 0;
  int         seq_n = 0;
  int         wait_cnt[N];
  logic       pv = 1'b0;

  rr_grant_arbiter #(.IDX_WIDTH(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic step(input logic [7:0] r);
    @(posedge clk);
    #1 req = r;
  endtask

  // Each cycle: drive req for this cycle, push the outputs expected in this cycle.
  task automatic grant(input logic [7:0] r, input int idx, input int n);
    exp_t e;
    repeat (n) begin
      step(r);
      e = {8'(1) << idx, 1'b1, 3'(idx), 1'b0};
      q.push_back(e);
    end
  endtask

  task automatic bubble(input logic [7:0] r, input logic t);
    exp_t e;
    step(r);
    e = {8'h00, 1'b0, 3'd0, t};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    chk("valid", 32'(gnt_valid), 32'(|gnt));
    if (q.size() > 0) begin
      e = q.pop_front();
      seq_n++;
      chk($sformatf("seq%0d {gnt,valid,idx,timeout}", seq_n),
          32'({gnt, gnt_valid, gnt_idx, timeout}), 32'(e));
    end
    if (!rst_n) begin
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      if (gnt_valid && !pv)
        for (int i = 0; i < N; i++)
          if (req[i] && !gnt[i]) begin
            wait_cnt[i]++;
            chk($sformatf("fair%0d tenures<=N", i), 32'(wait_cnt[i] <= N), 32'd1);
          end
      for (int i = 0; i < N; i++) if (!req[i] || gnt[i]) wait_cnt[i] = 0;
    end
    pv = gnt_valid;
  end

  initial begin
    exp_t e;
    bubble(8'h00, 1'b0);
    bubble(8'h00, 1'b0);
    #2 rst_n = 1'b1;
    // single requester 2, held 3 cycles
    bubble(8'h04, 1'b0);
    grant(8'h04, 2, 2);
    grant(8'h00, 2, 1);
    bubble(8'h00, 1'b0);
    bubble(8'h00, 1'b0);
    // from ptr=3 with 7,0,2 requesting; every tenure times out
    bubble(8'h85, 1'b0);
    grant(8'h85, 7, 4);
    bubble(8'h85, 1'b1);
    grant(8'h85, 0, 4);
    bubble(8'h85, 1'b1);
    grant(8'h85, 2, 4);
    bubble(8'h85, 1'b1);
    grant(8'h85, 7, 4);
    bubble(8'h00, 1'b1);
    bubble(8'h00, 1'b0);
    // timeout then re-grant of the same requester
    bubble(8'h20, 1'b0);
    grant(8'h20, 5, 4);
    bubble(8'h20, 1'b1);
    grant(8'h20, 5, 2);
    grant(8'h00, 5, 1);
    bubble(8'h00, 1'b0);
    // release coincides with hold reaching MAX_HOLD: no timeout
    bubble(8'h02, 1'b0);
    grant(8'h02, 1, 3);
    grant(8'h00, 1, 1);
    bubble(8'h00, 1'b0);
    // non-owner request dropped during tenure is never granted
    bubble(8'h18, 1'b0);
    grant(8'h18, 3, 2);
    grant(8'h00, 3, 1);
    bubble(8'h00, 1'b0);
    bubble(8'h00, 1'b0);
    // asynchronous reset mid-tenure
    bubble(8'hFF, 1'b0);
    grant(8'hFF, 4, 2);
    @(posedge clk);
    #1 req = 8'hFF;
    e = {8'h00, 1'b0, 3'd0, 1'b0};
    q.push_back(e);
    #1 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    grant(8'hFF, 0, 4);
    bubble(8'hFF, 1'b1);
    grant(8'hFF, 1, 1);
    grant(8'h00, 1, 1);
    bubble(8'h00, 1'b0);
    // random traffic: invariants and fairness checked by the monitor
    repeat (10000) step(8'($urandom | $urandom));
    repeat (4) step(8'h00);
    chk("drain queue empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
